// File: rtl/logic_unit_reg_if.sv
// Handshake/data bundle for logic_unit_reg.
// The master side is the producer of operands and the consumer of results;
// the slave side is the logic unit itself.
// Optional macro LOGIC_UNIT_POPCOUNT_EN adds the outPop signal.
interface logic_unit_reg_if #(
    parameter int WIDTH = 8
);
    localparam int PW = $clog2(WIDTH + 1);

    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [2:0]       inOp;
    logic             inAcc;
    logic             inClr;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outY;
    logic             outZero;
    logic             outOnes;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PW-1:0]    outPop;
`endif

    modport master (
        output inValid, inA, inB, inOp, inAcc, inClr, outReady,
        input  inReady, outValid, outY, outZero, outOnes
`ifdef LOGIC_UNIT_POPCOUNT_EN
        , input outPop
`endif
    );

    modport slave (
        input  inValid, inA, inB, inOp, inAcc, inClr, outReady,
        output inReady, outValid, outY, outZero, outOnes
`ifdef LOGIC_UNIT_POPCOUNT_EN
        , output outPop
`endif
    );
endinterface

// File: rtl/logic_unit_reg.sv
// Registered WIDTH-bit two-operand logic unit with accumulate mode.
// Eight bitwise operations, one-deep output register with backpressure,
// and an accumulator that can stand in for operand A.
// Optional macro LOGIC_UNIT_POPCOUNT_EN adds a registered population count
// of the result (bus.outPop).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. inReady = !outValid || outReady, so a result that is being
// drained this cycle can be replaced by a new one in the same edge. While
// outValid && !outReady the result and its flags hold still and no input
// is taken; the producer may change its data freely until it is accepted.
module logic_unit_reg #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_reg_if.slave  bus
);
    localparam int PW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] y_q;
    logic             valid_q;
    logic             zero_q;
    logic             ones_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] res;
    logic             in_ready;
    logic             accept;

    assign in_ready = !valid_q || bus.outReady;
    assign accept   = bus.inValid && in_ready;

    // Operand A: a same-cycle clear makes the accumulator read as ACC_INIT.
    always_comb begin
        op_a = bus.inA;
        if (bus.inAcc) begin
            op_a = bus.inClr ? ACC_INIT : acc_q;
        end
    end

    // Bitwise operation select.
    always_comb begin
        res = op_a;
        case (bus.inOp)
            OP_AND:  res = op_a & bus.inB;
            OP_OR:   res = op_a | bus.inB;
            OP_XOR:  res = op_a ^ bus.inB;
            OP_NOR:  res = ~(op_a | bus.inB);
            OP_NAND: res = ~(op_a & bus.inB);
            OP_XNOR: res = ~(op_a ^ bus.inB);
            OP_NOTA: res = ~op_a;
            OP_PASS: res = op_a;
            default: res = op_a;
        endcase
    end

    // Output register, flags and accumulator; an accepted result beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            acc_q   <= ACC_INIT;
        end else if (accept) begin
            valid_q <= 1'b1;
            y_q     <= res;
            zero_q  <= (res == '0);
            ones_q  <= &res;
            acc_q   <= res;
        end else begin
            if (bus.outReady) begin
                valid_q <= 1'b0;
            end
            if (bus.inClr) begin
                acc_q <= ACC_INIT;
            end
        end
    end

`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PW-1:0] pop_next;
    logic [PW-1:0] pop_q;

    // Population count of the value about to be written to the output.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_next = pop_next + PW'(res[i]);
        end
    end

    // Count register, loaded and held alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_q <= '0;
        end else if (accept) begin
            pop_q <= pop_next;
        end
    end

    assign bus.outPop = pop_q;
`endif

    assign bus.inReady  = in_ready;
    assign bus.outValid = valid_q;
    assign bus.outY     = y_q;
    assign bus.outZero  = zero_q;
    assign bus.outOnes  = ones_q;
endmodule

// File: tb/tb_logic_unit_reg.sv
// Bench for logic_unit_reg (WIDTH=8, ACC_INIT=0): directed sequences,
// a table of operation vectors and a randomized run against a truth-table
// reference model with an expected-result queue.
module tb_logic_unit_reg;
    localparam int             WIDTH    = 8;
    localparam logic [7:0]     ACC_INIT = 8'h00;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic_unit_reg_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_reg #(.WIDTH(WIDTH), .ACC_INIT(ACC_INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
        logic       o;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [3:0] tt[8];
    vec_t       vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inValid  = 1'b0;
        bus.inA      = 8'h00;
        bus.inB      = 8'h00;
        bus.inOp     = 3'b000;
        bus.inAcc    = 1'b0;
        bus.inClr    = 1'b0;
        bus.outReady = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic use_acc);
        bus.inValid = 1'b1;
        bus.inOp    = op;
        bus.inA     = a;
        bus.inB     = b;
        bus.inAcc   = use_acc;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] y, input logic z, input logic o);
        check({tag, "_valid"}, 32'(bus.outValid), 32'(v));
        check({tag, "_y"},     32'(bus.outY),     32'(y));
        check({tag, "_zero"},  32'(bus.outZero),  32'(z));
        check({tag, "_ones"},  32'(bus.outOnes),  32'(o));
`ifdef LOGIC_UNIT_POPCOUNT_EN
        check({tag, "_pop"},   32'(bus.outPop),   32'($countones(y)));
`endif
    endtask

    // Each result bit looks up its operation's truth table at index {a,b}.
    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [3:0] t;
        t = tt[op];
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = t[{a[i], b[i]}];
        end
        return r;
    endfunction

    initial begin
        logic       m_valid;
        logic [7:0] m_y;
        logic [7:0] m_acc;
        logic [7:0] opa;
        logic [7:0] r;
        logic       rdy;

        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
        tt[4] = 4'b0111; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;

        vecs[0] = '{3'b000, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
        vecs[3] = '{3'b011, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
        vecs[5] = '{3'b101, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0};
        vecs[6] = '{3'b110, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{3'b111, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
        vecs[8] = '{3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[9] = '{3'b001, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

        // Reset state.
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 8'h00, 1'b1, 1'b0);
        check("reset_inReady", 32'(bus.inReady), 32'd1);

        // Reset while a result is pending drops it.
        rst_n = 1'b1;
        bus.outReady = 1'b0;
        send(3'b111, 8'h55, 8'h00, 1'b0);
        tick();
        bus.inValid = 1'b0;
        check("pend_valid", 32'(bus.outValid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midreset_valid", 32'(bus.outValid), 32'd0);
        check("midreset_inReady", 32'(bus.inReady), 32'd1);
        rst_n = 1'b1;
        idle();
        tick();

        // Basic NOR.
        send(3'b011, 8'h0F, 8'h33, 1'b0);
        tick();
        bus.inValid = 1'b0;
        check_out("nor", 1'b1, 8'hC0, 1'b0, 1'b0);

        // Operation table, back-to-back.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            tick();
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].y, vecs[i].z, vecs[i].o);
        end
        bus.inValid = 1'b0;

        // Backpressure.
        send(3'b111, 8'h12, 8'h00, 1'b0);
        tick();
        check_out("bp_first", 1'b1, 8'h12, 1'b0, 1'b0);
        bus.outReady = 1'b0;
        send(3'b111, 8'h34, 8'h00, 1'b0);
        #1;
        check("bp_inReady0", 32'(bus.inReady), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.inA = 8'($urandom);
            bus.inOp = 3'($urandom_range(0, 7));
            tick();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 8'h12, 1'b0, 1'b0);
            check("bp_hold_inReady", 32'(bus.inReady), 32'd0);
        end
        bus.inA = 8'h34;
        bus.inOp = 3'b111;
        bus.outReady = 1'b1;
        #1;
        check("bp_inReady1", 32'(bus.inReady), 32'd1);
        tick();
        bus.inValid = 1'b0;
        check_out("bp_second", 1'b1, 8'h34, 1'b0, 1'b0);
        tick();
        check_out("drain", 1'b0, 8'h34, 1'b0, 1'b0);

        // Accumulate XOR chain after a clear.
        bus.inClr = 1'b1;
        tick();
        bus.inClr = 1'b0;
        send(3'b010, 8'hAA, 8'hFF, 1'b1);
        tick();
        check_out("acc0", 1'b1, 8'hFF, 1'b0, 1'b1);
        bus.inB = 8'h0F;
        tick();
        check_out("acc1", 1'b1, 8'hF0, 1'b0, 1'b0);
        bus.inB = 8'hF0;
        tick();
        check_out("acc2", 1'b1, 8'h00, 1'b1, 1'b0);
        bus.inValid = 1'b0;

        // Clear colliding with an accumulate transaction.
        send(3'b111, 8'hF0, 8'h00, 1'b0);
        tick();
        bus.inClr = 1'b1;
        send(3'b001, 8'hFF, 8'h01, 1'b1);
        tick();
        bus.inClr = 1'b0;
        check_out("clr_coll", 1'b1, 8'h01, 1'b0, 1'b0);
        send(3'b111, 8'hFF, 8'h00, 1'b1);
        tick();
        bus.inValid = 1'b0;
        check_out("acc_after_coll", 1'b1, 8'h01, 1'b0, 1'b0);
        bus.outReady = 1'b0;
        bus.inClr = 1'b1;
        tick();
        bus.inClr = 1'b0;
        check_out("clr_alone", 1'b1, 8'h01, 1'b0, 1'b0);
        bus.outReady = 1'b1;
        send(3'b111, 8'hFF, 8'h00, 1'b1);
        tick();
        bus.inValid = 1'b0;
        check_out("acc_cleared", 1'b1, 8'h00, 1'b1, 1'b0);

        // Randomized run against the reference model.
        rst_n = 1'b0;
        tick();
        m_valid = 1'b0;
        m_y = 8'h00;
        m_acc = ACC_INIT;
        exp_q.delete();
        for (int c = 0; c < 500; c++) begin
            rst_n        = ($urandom_range(0, 59) != 0);
            bus.inValid  = ($urandom_range(0, 3) != 0);
            bus.outReady = ($urandom_range(0, 2) != 0);
            bus.inAcc    = 1'($urandom_range(0, 1));
            bus.inClr    = ($urandom_range(0, 9) == 0);
            bus.inOp     = 3'($urandom_range(0, 7));
            bus.inA      = 8'($urandom);
            bus.inB      = 8'($urandom);
            #1;
            rdy = !m_valid || bus.outReady;
            check("rnd_inReady", 32'(bus.inReady), 32'(rdy));
            if (!rst_n) begin
                m_valid = 1'b0;
                m_y = 8'h00;
                m_acc = ACC_INIT;
                exp_q.delete();
            end else begin
                if (m_valid && bus.outReady && exp_q.size() > 0) begin
                    check("rnd_consume", 32'(bus.outY), 32'(exp_q.pop_front()));
                end
                if (bus.inValid && rdy) begin
                    opa = bus.inAcc ? (bus.inClr ? ACC_INIT : m_acc) : bus.inA;
                    r = ref_op(bus.inOp, opa, bus.inB);
                    m_valid = 1'b1;
                    m_y = r;
                    m_acc = r;
                    exp_q.push_back(r);
                end else begin
                    if (bus.outReady) m_valid = 1'b0;
                    if (bus.inClr) m_acc = ACC_INIT;
                end
            end
            tick();
            check_out("rnd", m_valid, m_y, (m_y == 8'h00), &m_y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_unit_reg.md
Name: logic_unit_reg

Overview:
- Parametrised, registered bitwise two-operand logic unit. Generalises the fixed 8-bit NOR slice to WIDTH bits and eight selectable operations.
- Adds a valid/ready handshake, a one-deep output register with backpressure, and an accumulate mode that feeds the last result back as operand A.
- Sits between datapath producers and consumers in the ALU/logic tree wherever a pipelined bitwise stage is needed.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- ACC_INIT, 0, value loaded into the accumulator on reset and on clear (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- inValid  input  1  input transaction valid
- inReady  output  1  block can accept input this cycle
- inA  input  WIDTH  operand A (ignored when inAcc=1)
- inB  input  WIDTH  operand B
- inOp  input  3  operation select, sampled with the transaction
- inAcc  input  1  1 = use accumulator as operand A
- inClr  input  1  clear accumulator to ACC_INIT
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result
- outY  output  WIDTH  registered result
- outZero  output  1  outY == 0, registered with outY
- outOnes  output  1  outY all ones, registered with outY

Behaviour:
- Reset: rst_n=0 sampled at a clk edge gives outValid=0, outY=0, outZero=1, outOnes=0, acc=ACC_INIT. Reset mid-operation drops any pending result with no handshake. inReady=1 during and after reset.
- inReady = !outValid || outReady (combinational; single output register with pass-through on drain).
- Accept: inValid && inReady at the edge. Next cycle: outY=f(opA,inB), outValid=1, flags updated, acc=result. Latency is 1 cycle.
- Holding: outValid && !outReady means outY and flags are held stable and no input is accepted. inA/inB/inOp/inAcc may change freely while not accepted.
- Drain: outValid && outReady && !accept gives outValid=0 next cycle; outY holds its last value.
- Simultaneous drain and accept: outY is replaced and outValid stays 1 (full throughput, one result per cycle).
- opA = inAcc ? (clear-this-cycle ? ACC_INIT : acc) : inA.
- inOp encoding:
  - 000 AND; 001 OR; 010 XOR; 011 NOR
  - 100 NAND; 101 XNOR; 110 NOT A (inB ignored); 111 PASS A
  - All bitwise and WIDTH-exact; no carries.
- inClr: acts at the edge regardless of inValid/handshake.
  - Without a same-cycle accept: acc=ACC_INIT next cycle; outY/outValid are unaffected.
  - With a same-cycle accept: that transaction's opA uses ACC_INIT (if inAcc=1), and acc takes the new result (the result wins over the clear).
- acc updates only on accepted transactions or on clear, never on a stall.
- outZero/outOnes are derived from the value written to outY and held with it. For WIDTH=1, outZero = !outY and outOnes = outY.

Optional Feature:
- Macro: LOGIC_UNIT_POPCOUNT_EN
- Defined: adds output port outPop, width $clog2(WIDTH+1). It is the population count of the value written to outY, registered with outY, reset to 0, and held during stalls.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, ACC_INIT=0):
- Reset, then sample: outValid=0, outY=0x00, outZero=1, inReady=1. Assert rst_n=0 while outValid=1: next cycle outValid=0.
- Accept inA=0x0F, inB=0x33, inOp=011 (NOR) with outReady=1: one cycle later outY=0xC0, outValid=1, outZero=0, outOnes=0 (outPop=2 if enabled).
- Sweep all 8 ops with A=0xA5, B=0x3C. Required outY in op order: 0x24, 0xBD, 0x99, 0x42, 0xDB, 0x66, 0x5A, 0xA5.
- Backpressure: hold outReady=0 after one result and present a second. inReady=0, the second is not accepted, outY is stable for 5 cycles. Raise outReady: the second is accepted in the same cycle and appears next cycle.
- Accumulate: clear, then inAcc=1 XOR with inB=0xFF, 0x0F, 0xF0 on back-to-back accepts. outY sequence is 0xFF, 0xF0, 0x00 with outZero=1 on the last; one result per cycle.
- Clear collision: with acc=0xF0, assert inClr with an accepted inAcc=1, OR, inB=0x01. Result is 0x01 (ACC_INIT used) and acc=0x01. A following inClr alone gives acc=0x00 while outY stays 0x01.
